lcd_bus_rx: RTL and testbench

LCD_BUS_RX -- requirements
Module: lcd_bus_rx

---
 rtl/lcd_pkg.sv | 67 ++++++
 rtl/lcd_busy_timer.sv | 84 ++++++++
 rtl/lcd_bus_rx.sv | 192 +++++++++++++++++++
 tb/tb_lcd_bus_rx.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
//------------------------------------------------------------------------------
// Module  : lcd_pkg
// Brief   : Shared opcodes, address constants and cursor helpers for lcd_bus_rx.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lcd_pkg;

  localparam logic [7:0] ASCII_BLANK = 8'h20;
  localparam logic [6:0] LINE0_BASE  = 7'h00;
  localparam logic [6:0] LINE1_BASE  = 7'h40;
  localparam int         NUM_CHARS   = 32;

  // Each opcode is identified by its highest set bit.
  localparam logic [7:0] OP_SET_DDRAM = 8'h80;
  localparam logic [7:0] OP_SET_CGRAM = 8'h40;
  localparam logic [7:0] OP_FUNC_SET  = 8'h20;
  localparam logic [7:0] OP_SHIFT     = 8'h10;
  localparam logic [7:0] OP_DISP_CTRL = 8'h08;
  localparam logic [7:0] OP_ENTRY     = 8'h04;
  localparam logic [7:0] OP_HOME      = 8'h02;
  localparam logic [7:0] OP_CLEAR     = 8'h01;

  typedef enum logic [3:0] {
    INS_NOP,
    INS_CLEAR,
    INS_HOME,
    INS_ENTRY,
    INS_DISP,
    INS_SHIFT,
    INS_FUNC,
    INS_CGRAM,
    INS_DDRAM
  } instr_e;

  function automatic instr_e decode_instr(input logic [7:0] op);
    instr_e r;
    r = INS_NOP;
    if      ((op & OP_SET_DDRAM) != 8'h00) r = INS_DDRAM;
    else if ((op & OP_SET_CGRAM) != 8'h00) r = INS_CGRAM;
    else if ((op & OP_FUNC_SET)  != 8'h00) r = INS_FUNC;
    else if ((op & OP_SHIFT)     != 8'h00) r = INS_SHIFT;
    else if ((op & OP_DISP_CTRL) != 8'h00) r = INS_DISP;
    else if ((op & OP_ENTRY)     != 8'h00) r = INS_ENTRY;
    else if ((op & OP_HOME)      != 8'h00) r = INS_HOME;
    else if ((op & OP_CLEAR)     != 8'h00) r = INS_CLEAR;
    return r;
  endfunction

  // Cursor moves within a 16-column line and wraps onto the other line.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    logic [6:0] other_line;
    logic [6:0] r;
    other_line = a[6] ? LINE0_BASE : LINE1_BASE;
    if (inc) r = (a[3:0] == 4'hF) ? other_line : {a[6], 2'b00, a[3:0] + 4'h1};
    else     r = (a[3:0] == 4'h0) ? (other_line | 7'h0F) : {a[6], 2'b00, a[3:0] - 4'h1};
    return r;
  endfunction

  function automatic logic [4:0] char_index(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_busy_timer.sv
//------------------------------------------------------------------------------
// Module  : lcd_busy_timer
// Brief   : Busy down-counter with the 32-cycle clear sweep index.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_busy_timer
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       start_clear,
  output logic       busy,
  output logic       sweep_en,
  output logic [4:0] sweep_idx
);

  localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    T_IDLE,
    T_SWEEP,
    T_BUSY
  } tstate_e;

  tstate_e            state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         idx_q, idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= T_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // cnt holds the remaining busy cycles minus one; the state leaves on zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      T_IDLE: begin
        if (start_clear) begin
          state_d = T_SWEEP;
          cnt_d   = CNT_W'(CLEAR_CYCLES - 1);
          idx_d   = '0;
        end else if (start) begin
          state_d = T_BUSY;
          cnt_d   = CNT_W'(BUSY_CYCLES - 1);
        end
      end
      T_SWEEP: begin
        cnt_d = cnt_q - 1'b1;
        idx_d = idx_q + 1'b1;
        if (cnt_q == '0)                     state_d = T_IDLE;
        else if (idx_q == 5'(NUM_CHARS - 1)) state_d = T_BUSY;
      end
      T_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = T_IDLE;
      end
      default: state_d = T_IDLE;
    endcase
  end

  assign busy      = (state_q != T_IDLE);
  assign sweep_en  = (state_q == T_SWEEP);
  assign sweep_idx = idx_q;

endmodule

`default_nettype wire

// File: rtl/lcd_bus_rx.sv
//------------------------------------------------------------------------------
// Module  : lcd_bus_rx
// Brief   : HD44780-style character LCD bus receiver with 2x16 display memory.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_bus_rx
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_db,
  output logic [7:0] db_out,
  output logic       db_oe,
  output logic       busy,
  output logic [6:0] cur_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       entry_shift,
  output logic       func_8bit,
  output logic       func_2line,
  input  logic [4:0] peek_idx,
  output logic [7:0] peek_char,
  output logic       err_overrun
);

  logic       e_meta_q, e_sync_q, e_prev_q;
  logic       cap_rs_q, cap_rs_d;
  logic       cap_rw_q, cap_rw_d;
  logic [7:0] cap_db_q, cap_db_d;
  logic [6:0] cur_addr_q, cur_addr_d;
  logic [7:0] chars_q [NUM_CHARS];
  logic [7:0] chars_d [NUM_CHARS];
  logic       disp_on_q, disp_on_d;
  logic       cursor_on_q, cursor_on_d;
  logic       blink_on_q, blink_on_d;
  logic       entry_inc_q, entry_inc_d;
  logic       entry_shift_q, entry_shift_d;
  logic       func_8bit_q, func_8bit_d;
  logic       func_2line_q, func_2line_d;
  logic       err_overrun_q, err_overrun_d;

  logic       e_fall;
  logic       timer_start, timer_clear;
  logic       timer_busy, sweep_en;
  logic [4:0] sweep_idx;
  instr_e     instr;

  lcd_busy_timer #(
    .BUSY_CYCLES  (BUSY_CYCLES),
    .CLEAR_CYCLES (CLEAR_CYCLES)
  ) u_busy_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (timer_start),
    .start_clear (timer_clear),
    .busy        (timer_busy),
    .sweep_en    (sweep_en),
    .sweep_idx   (sweep_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_meta_q      <= 1'b0;
      e_sync_q      <= 1'b0;
      e_prev_q      <= 1'b0;
      cap_rs_q      <= 1'b0;
      cap_rw_q      <= 1'b0;
      cap_db_q      <= 8'h00;
      cur_addr_q    <= LINE0_BASE;
      for (int i = 0; i < NUM_CHARS; i++) chars_q[i] <= ASCII_BLANK;
      disp_on_q     <= 1'b0;
      cursor_on_q   <= 1'b0;
      blink_on_q    <= 1'b0;
      entry_inc_q   <= 1'b1;
      entry_shift_q <= 1'b0;
      func_8bit_q   <= 1'b1;
      func_2line_q  <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      e_meta_q      <= lcd_e;
      e_sync_q      <= e_meta_q;
      e_prev_q      <= e_sync_q;
      cap_rs_q      <= cap_rs_d;
      cap_rw_q      <= cap_rw_d;
      cap_db_q      <= cap_db_d;
      cur_addr_q    <= cur_addr_d;
      chars_q       <= chars_d;
      disp_on_q     <= disp_on_d;
      cursor_on_q   <= cursor_on_d;
      blink_on_q    <= blink_on_d;
      entry_inc_q   <= entry_inc_d;
      entry_shift_q <= entry_shift_d;
      func_8bit_q   <= func_8bit_d;
      func_2line_q  <= func_2line_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign e_fall = e_prev_q & ~e_sync_q;
  assign instr  = decode_instr(cap_db_q);

  always_comb begin
    cap_rs_d      = e_sync_q ? lcd_rs : cap_rs_q;
    cap_rw_d      = e_sync_q ? lcd_rw : cap_rw_q;
    cap_db_d      = e_sync_q ? lcd_db : cap_db_q;
    cur_addr_d    = cur_addr_q;
    chars_d       = chars_q;
    disp_on_d     = disp_on_q;
    cursor_on_d   = cursor_on_q;
    blink_on_d    = blink_on_q;
    entry_inc_d   = entry_inc_q;
    entry_shift_d = entry_shift_q;
    func_8bit_d   = func_8bit_q;
    func_2line_d  = func_2line_q;
    err_overrun_d = err_overrun_q;
    timer_start   = 1'b0;
    timer_clear   = 1'b0;

    if (sweep_en) chars_d[sweep_idx] = ASCII_BLANK;

    if (e_fall) begin
      if (cap_rw_q) begin
        // Reads are serviced even while busy; only a data read moves the cursor.
        if (cap_rs_q) cur_addr_d = step_addr(cur_addr_q, entry_inc_q);
      end else if (timer_busy) begin
        err_overrun_d = 1'b1;
      end else if (cap_rs_q) begin
        chars_d[char_index(cur_addr_q)] = cap_db_q;
        cur_addr_d  = step_addr(cur_addr_q, entry_inc_q);
        timer_start = 1'b1;
      end else begin
        timer_start = 1'b1;
        case (instr)
          INS_DDRAM: cur_addr_d = {cap_db_q[6], 2'b00, cap_db_q[3:0]};
          INS_CGRAM: ;
          INS_FUNC: begin
            func_8bit_d  = cap_db_q[4];
            func_2line_d = cap_db_q[3];
          end
          INS_SHIFT: begin
            if (!cap_db_q[3]) cur_addr_d = step_addr(cur_addr_q, cap_db_q[2]);
          end
          INS_DISP: begin
            disp_on_d   = cap_db_q[2];
            cursor_on_d = cap_db_q[1];
            blink_on_d  = cap_db_q[0];
          end
          INS_ENTRY: begin
            entry_inc_d   = cap_db_q[1];
            entry_shift_d = cap_db_q[0];
          end
          INS_HOME:  cur_addr_d = LINE0_BASE;
          INS_CLEAR: begin
            cur_addr_d  = LINE0_BASE;
            timer_clear = 1'b1;
          end
          default:   timer_start = 1'b0;
        endcase
      end
    end
  end

  // e_prev_q gates the first E-high cycle, before the capture registers are fresh.
  assign db_oe  = e_sync_q & e_prev_q & cap_rw_q;
  assign db_out = !db_oe   ? 8'h00 :
                  cap_rs_q ? chars_q[char_index(cur_addr_q)] : {timer_busy, cur_addr_q};

  assign busy        = timer_busy;
  assign cur_addr    = cur_addr_q;
  assign disp_on     = disp_on_q;
  assign cursor_on   = cursor_on_q;
  assign blink_on    = blink_on_q;
  assign entry_inc   = entry_inc_q;
  assign entry_shift = entry_shift_q;
  assign func_8bit   = func_8bit_q;
  assign func_2line  = func_2line_q;
  assign err_overrun = err_overrun_q;
  assign peek_char   = chars_q[peek_idx];

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_rx.sv
//------------------------------------------------------------------------------
// Module  : tb_lcd_bus_rx
// Brief   : Self-checking bench for lcd_bus_rx with a behavioural display model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lcd_bus_rx;

  localparam int BUSY_CYCLES  = 40;
  localparam int CLEAR_CYCLES = 1600;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_db = 8'h00;
  logic [4:0] peek_idx = 5'd0;
  logic [7:0] db_out, peek_char;
  logic [6:0] cur_addr;
  logic       db_oe, busy, disp_on, cursor_on, blink_on, entry_inc, entry_shift;
  logic       func_8bit, func_2line, err_overrun;

  lcd_bus_rx #(.BUSY_CYCLES(BUSY_CYCLES), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_db(lcd_db), .db_out(db_out), .db_oe(db_oe), .busy(busy), .cur_addr(cur_addr),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .entry_inc(entry_inc), .entry_shift(entry_shift), .func_8bit(func_8bit),
    .func_2line(func_2line), .peek_idx(peek_idx), .peek_char(peek_char),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  logic [7:0] m_chars [32];
  logic [6:0] m_addr;
  bit m_inc, m_shift, m_disp, m_cur, m_blink, m_f8, m_f2;

  int busy_run = 0;
  int busy_len = 0;
  always @(negedge clk) begin
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      busy_len = busy_run;
      busy_run = 0;
    end
  end

  // Linear position 0..31 over both lines, so wrap falls out of modulo arithmetic.
  function automatic logic [6:0] m_step(input logic [6:0] a, input bit inc);
    int pos;
    logic [4:0] p;
    pos = (a[6] ? 16 : 0) + int'(a[3:0]);
    pos = inc ? (pos + 1) % 32 : (pos + 31) % 32;
    p = pos[4:0];
    return {p[4], 2'b00, p[3:0]};
  endfunction

  function automatic int m_idx(input logic [6:0] a);
    return (a[6] ? 16 : 0) + int'(a[3:0]);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_chars[i] = 8'h20;
    m_addr = 7'h00; m_inc = 1; m_shift = 0; m_disp = 0; m_cur = 0; m_blink = 0;
    m_f8 = 1; m_f2 = 0;
  endtask

  task automatic m_apply(input bit rs, input logic [7:0] db);
    if (rs) begin
      m_chars[m_idx(m_addr)] = db;
      m_addr = m_step(m_addr, m_inc);
    end else if (db[7]) m_addr = {db[6], 2'b00, db[3:0]};
    else if (db[6]) ;
    else if (db[5]) begin m_f8 = db[4]; m_f2 = db[3]; end
    else if (db[4]) begin if (!db[3]) m_addr = m_step(m_addr, db[2]); end
    else if (db[3]) begin m_disp = db[2]; m_cur = db[1]; m_blink = db[0]; end
    else if (db[2]) begin m_inc = db[1]; m_shift = db[0]; end
    else if (db[1]) m_addr = 7'h00;
    else if (db[0]) begin
      for (int i = 0; i < 32; i++) m_chars[i] = 8'h20;
      m_addr = 7'h00;
    end
  endtask

  task automatic bus_cycle(input bit rs, input bit rw, input logic [7:0] db);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_db = db; lcd_e = 1'b1;
    repeat (6) @(negedge clk);
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic bus_write(input bit rs, input logic [7:0] db, input bit accepted);
    bus_cycle(rs, 1'b0, db);
    if (accepted) m_apply(rs, db);
  endtask

  task automatic bus_read(input bit rs, input bit exp_busy, input string name);
    logic [7:0] exp;
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b1; lcd_db = 8'hA5; lcd_e = 1'b1;
    exp_q.push_back(rs ? m_chars[m_idx(m_addr)] : {exp_busy, m_addr});
    repeat (4) @(negedge clk);
    checks++;
    if (db_oe !== 1'b1) begin
      errors++; $display("FAIL %s db_oe: got %b expected 1", name, db_oe);
    end
    exp = exp_q.pop_front();
    checks++;
    if (db_out !== exp) begin
      errors++; $display("FAIL %s db_out: got %h expected %h", name, db_out, exp);
    end
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
    if (rs) m_addr = m_step(m_addr, m_inc);
    checks++;
    if (db_oe !== 1'b0 || db_out !== 8'h00) begin
      errors++; $display("FAIL %s idle bus: got oe=%b out=%h expected oe=0 out=00", name, db_oe, db_out);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL wait_idle timeout: got busy=%b expected 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic peek_check(input int idx, input string name);
    logic [7:0] exp;
    exp_q.push_back(m_chars[idx]);
    peek_idx = 5'(idx);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (peek_char !== exp) begin
      errors++; $display("FAIL %s peek[%0d]: got %h expected %h", name, idx, peek_char, exp);
    end
  endtask

  task automatic addr_check(input string name);
    checks++;
    if (cur_addr !== m_addr) begin
      errors++; $display("FAIL %s cur_addr: got %h expected %h", name, cur_addr, m_addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    for (int i = 0; i < 32; i++) peek_check(i, "reset");
    addr_check("reset");
    checks++;
    if ({busy, disp_on, cursor_on, blink_on, entry_inc, entry_shift, func_8bit, func_2line, err_overrun, db_oe}
        !== 10'b0000101000) begin
      errors++;
      $display("FAIL reset flags: got %b expected 0000101000",
               {busy, disp_on, cursor_on, blink_on, entry_inc, entry_shift, func_8bit, func_2line, err_overrun, db_oe});
    end
  endtask

  task automatic test_basic_write();
    bus_write(0, 8'h0C, 1); wait_idle();
    bus_write(0, 8'h06, 1); wait_idle();
    bus_write(1, 8'h41, 1);
    peek_check(0, "basic");
    addr_check("basic");
    checks++;
    if (disp_on !== m_disp || entry_inc !== m_inc || cursor_on !== m_cur) begin
      errors++;
      $display("FAIL basic ctrl: got disp=%b inc=%b cur=%b expected disp=%b inc=%b cur=%b",
               disp_on, entry_inc, cursor_on, m_disp, m_inc, m_cur);
    end
    wait_idle();
  endtask

  task automatic test_line_wrap();
    bus_write(0, 8'h8F, 1); wait_idle();
    bus_write(1, 8'h42, 1);
    peek_check(15, "wrap_line0");
    addr_check("wrap_line0");
    wait_idle();
    bus_write(0, 8'hCF, 1); wait_idle();
    bus_write(1, 8'h43, 1); wait_idle();
    peek_check(31, "wrap_line1");
    addr_check("wrap_line1");
    bus_write(0, 8'h04, 1); wait_idle();
    bus_write(1, 8'h44, 1); wait_idle();
    peek_check(0, "wrap_dec");
    addr_check("wrap_dec");
    checks++;
    if (entry_inc !== 1'b0) begin
      errors++; $display("FAIL wrap_dec entry_inc: got %b expected 0", entry_inc);
    end
    bus_write(0, 8'h06, 1); wait_idle();
    bus_write(0, 8'h14, 1); wait_idle();
    addr_check("cursor_shift");
    bus_write(0, 8'h38, 1); wait_idle();
    checks++;
    if (func_8bit !== m_f8 || func_2line !== m_f2) begin
      errors++; $display("FAIL func_set: got %b%b expected %b%b", func_8bit, func_2line, m_f8, m_f2);
    end
  endtask

  task automatic test_noop();
    bus_write(0, 8'h00, 1);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL noop busy: got %b expected 0", busy);
    end
    bus_write(0, 8'h02, 1);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL home busy: got %b expected 1", busy);
    end
    addr_check("home");
    wait_idle();
  endtask

  task automatic test_status_read();
    bus_write(0, 8'h85, 1); wait_idle();
    bus_write(1, 8'h55, 1);
    bus_read(0, 1'b1, "status_busy");
    repeat (BUSY_CYCLES) @(negedge clk);
    bus_read(0, 1'b0, "status_idle");
    bus_write(0, 8'h85, 1);
    bus_read(1, 1'b1, "data_read");
    addr_check("data_read");
    wait_idle();
  endtask

  task automatic test_clear_overrun();
    bus_write(0, 8'h01, 1);
    repeat (88) @(negedge clk);
    bus_write(1, 8'h41, 0);
    checks++;
    if (err_overrun !== 1'b1) begin
      errors++; $display("FAIL overrun flag: got %b expected 1", err_overrun);
    end
    wait_idle();
    checks++;
    if (busy_len != CLEAR_CYCLES) begin
      errors++; $display("FAIL clear busy length: got %0d expected %0d", busy_len, CLEAR_CYCLES);
    end
    for (int i = 0; i < 32; i++) peek_check(i, "clear");
    addr_check("clear");
  endtask

  task automatic test_reset_mid_clear();
    bus_write(0, 8'hC0, 1); wait_idle();
    for (int i = 0; i < 16; i++) begin
      bus_write(1, 8'h61 + 8'(i), 1); wait_idle();
    end
    peek_check(20, "prefill");
    checks++;
    if (err_overrun !== 1'b1) begin
      errors++; $display("FAIL overrun sticky: got %b expected 1", err_overrun);
    end
    bus_write(0, 8'h01, 0);
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mid_clear busy before reset: got %b expected 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    checks++;
    if ({busy, disp_on, cursor_on, blink_on, entry_inc, entry_shift, func_8bit, func_2line, err_overrun, db_oe}
        !== 10'b0000101000) begin
      errors++;
      $display("FAIL mid_clear flags: got %b expected 0000101000",
               {busy, disp_on, cursor_on, blink_on, entry_inc, entry_shift, func_8bit, func_2line, err_overrun, db_oe});
    end
    addr_check("mid_clear");
    for (int i = 0; i < 32; i++) peek_check(i, "mid_clear");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_line_wrap();
    test_noop();
    test_status_read();
    test_clear_overrun();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
